flash_read_responder: RTL

FLASH_READ_RESPONDER -- requirements
Module: flash_read_responder

---
 rtl/flash_read_responder_if.sv | 28 ++
 rtl/flash_read_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/flash_read_responder_if.sv
// Flash-side read bus of the flash read responder: request, stall and read-data return.
// The slave modport is the responder's view; the master modport is the requester's view.
interface flash_read_responder_if;
  logic        flsh_read;
  logic [22:0] flsh_address;
  logic [3:0]  flsh_byteenable;
  logic        flsh_waitrequest;
  logic [31:0] flsh_readdata;
  logic        flsh_readdatavalid;

  modport slave (
    input  flsh_read,
    input  flsh_address,
    input  flsh_byteenable,
    output flsh_waitrequest,
    output flsh_readdata,
    output flsh_readdatavalid
  );

  modport master (
    output flsh_read,
    output flsh_address,
    output flsh_byteenable,
    input  flsh_waitrequest,
    input  flsh_readdata,
    input  flsh_readdatavalid
  );
endinterface

// File: rtl/flash_read_responder.sv
// Queues flash reads in a command FIFO and serves them one at a time from a fixed-latency memory.
// Define FLASH_RESP_THROTTLE_EN to stall the cycle after every accepted read.
module flash_read_responder #(
  parameter int unsigned ACCESS_CYCLES = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  flash_read_responder_if.slave       flsh,
  output logic                        mem_rd,
  output logic [22:0]                 mem_addr,
  input  logic [31:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] outstanding
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StReturn = 2'd2;

  // FIFO entry is {address, byteenable}
  logic [26:0]     fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, push, pop, wait_req;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      be_q, be_d;
  logic [22:0]     addr_q, addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic [31:0]     rdata_q, rdata_d, masked;
  logic            rvalid_q, rvalid_d;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

`ifdef FLASH_RESP_THROTTLE_EN
  logic accepted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_q <= 1'b0;
    end else begin
      accepted_q <= push;
    end
  end

  assign wait_req = rst | full | accepted_q;
`else
  assign wait_req = rst | full;
`endif

  assign push    = flsh.flsh_read & ~wait_req;
  assign pop     = (state_q == StIdle) & ~empty;
  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {flsh.flsh_address, flsh.flsh_byteenable};
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) masked[8*i +: 8] = mem_rdata[8*i +: 8];
    end
  end

  // Memory data becomes valid in the RETURN cycle; it is captured at the end of it so the
  // response shows up in the following idle cycle, overlapping the next pop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    be_d     = be_q;
    addr_d   = addr_q;
    mem_rd_d = 1'b0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          {addr_d, be_d} = fifo_mem[rd_ptr_q];
          mem_rd_d       = 1'b1;
          cnt_d          = 4'(ACCESS_CYCLES);
          state_d        = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StReturn;
      end
      StReturn: begin
        rdata_d  = masked;
        rvalid_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      mem_rd_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      mem_rd_q <= mem_rd_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign mem_rd                  = mem_rd_q;
  assign mem_addr                = addr_q;
  assign flsh.flsh_waitrequest   = wait_req;
  assign flsh.flsh_readdata      = rdata_q;
  assign flsh.flsh_readdatavalid = rvalid_q;
  assign outstanding             = count_q + CntW'(state_q != StIdle);

endmodule
